// File: rtl/prewish_button_poller_pkg.sv
// Shared FSM encoding, default timing and helpers for the button poller.
// The state encodings are also what the debounce stage's FSM documentation refers to.
package prewish_button_poller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REQ    = 2'b01,
        ST_WAIT   = 2'b11,
        ST_UPDATE = 2'b10
    } poll_state_e;

`ifdef SIM_STEP
    localparam int DEF_POLL_PERIOD = 37;
    localparam int DEF_TIMEOUT     = 8;
`else
    localparam int DEF_POLL_PERIOD = 50000;
    localparam int DEF_TIMEOUT     = 16;
`endif

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/prewish_button_poller.sv
// Polls the debounce stage over its strobe/data handshake, holds the latest button byte
// and emits press/release/timeout pulses; an unanswered request is abandoned and counted.
module prewish_button_poller
    import prewish_button_poller_pkg::*;
#(
    parameter int POLL_PERIOD = DEF_POLL_PERIOD,
    parameter int POLL_BITS   = 16,
    parameter int REQ_CYCLES  = 2,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int TO_BITS     = 5
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    output logic       STB_O,
    input  logic       STB_I,
    input  logic [7:0] DAT_I,
    output logic [7:0] o_state,
    output logic [7:0] o_pressed,
    output logic [7:0] o_released,
    output logic       o_timeout,
    output logic [7:0] o_err_cnt
);

    localparam int REQ_BITS = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;

    poll_state_e         state_q, state_d;
    logic [POLL_BITS-1:0] poll_q, poll_d;
    logic [REQ_BITS-1:0]  req_q, req_d;
    logic [TO_BITS-1:0]   to_q, to_d;
    logic                 stb_q, stb_d;
    logic [7:0]           cap_q, cap_d;
    logic [7:0]           st_q, st_d;
    logic [7:0]           pr_q, pr_d;
    logic [7:0]           rl_q, rl_d;
    logic                 tmo_q, tmo_d;
    logic [7:0]           err_q, err_d;
    logic                 primed_q, primed_d;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q  <= ST_IDLE;
            poll_q   <= POLL_BITS'(POLL_PERIOD - 1);
            req_q    <= '0;
            to_q     <= '0;
            stb_q    <= 1'b0;
            cap_q    <= '0;
            st_q     <= '0;
            pr_q     <= '0;
            rl_q     <= '0;
            tmo_q    <= 1'b0;
            err_q    <= '0;
            primed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            poll_q   <= poll_d;
            req_q    <= req_d;
            to_q     <= to_d;
            stb_q    <= stb_d;
            cap_q    <= cap_d;
            st_q     <= st_d;
            pr_q     <= pr_d;
            rl_q     <= rl_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            primed_q <= primed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        poll_d   = poll_q;
        req_d    = req_q;
        to_d     = to_q;
        stb_d    = stb_q;
        cap_d    = cap_q;
        st_d     = st_q;
        pr_d     = '0;
        rl_d     = '0;
        tmo_d    = 1'b0;
        err_d    = err_q;
        primed_d = primed_q;

        case (state_q)
            ST_IDLE: begin
                stb_d = 1'b0;
                if (poll_q == '0) begin
                    state_d = ST_REQ;
                    req_d   = REQ_BITS'(REQ_CYCLES - 1);
                    stb_d   = 1'b1;
                end else begin
                    poll_d = poll_q - 1'b1;
                end
            end
            ST_REQ: begin
                if (req_q == '0) begin
                    state_d = ST_WAIT;
                    stb_d   = 1'b0;
                    to_d    = TO_BITS'(TIMEOUT - 1);
                end else begin
                    req_d = req_q - 1'b1;
                end
            end
            ST_WAIT: begin
                // A reply arriving on the last allowed cycle still counts as an answer.
                if (STB_I) begin
                    state_d = ST_UPDATE;
                    cap_d   = DAT_I;
                end else if (to_q == '0) begin
                    state_d = ST_IDLE;
                    poll_d  = POLL_BITS'(POLL_PERIOD - 1);
                    tmo_d   = 1'b1;
                    err_d   = sat_inc8(err_q);
                end else begin
                    to_d = to_q - 1'b1;
                end
            end
            ST_UPDATE: begin
                // The first capture after reset only establishes the baseline.
                if (primed_q) begin
                    pr_d = cap_q & ~st_q;
                    rl_d = ~cap_q & st_q;
                end
                st_d     = cap_q;
                primed_d = 1'b1;
                state_d  = ST_IDLE;
                poll_d   = POLL_BITS'(POLL_PERIOD - 1);
            end
            default: begin
                state_d = ST_IDLE;
                stb_d   = 1'b0;
                poll_d  = POLL_BITS'(POLL_PERIOD - 1);
            end
        endcase
    end

    assign STB_O      = stb_q;
    assign o_state    = st_q;
    assign o_pressed  = pr_q;
    assign o_released = rl_q;
    assign o_timeout  = tmo_q;
    assign o_err_cnt  = err_q;

endmodule

// File: tb/tb_prewish_button_poller.sv
// Directed and randomized bench for prewish_button_poller with a behavioural responder
// standing in for the debounce stage and a transaction-level model of the held status.
module tb_prewish_button_poller;

    localparam int P = 8;
    localparam int R = 2;
    localparam int T = 6;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b1;
    logic       STB_O;
    logic       STB_I = 1'b0;
    logic [7:0] DAT_I = 8'h00;
    logic [7:0] o_state, o_pressed, o_released, o_err_cnt;
    logic       o_timeout;

    int total  = 0;
    int passes = 0;

    logic [7:0] exp_state = 8'h00;
    int         exp_err   = 0;
    bit         primed    = 1'b0;
    int         p0_cnt    = 0;
    int         r0_cnt    = 0;
    int         tmo_cnt   = 0;

    prewish_button_poller #(
        .POLL_PERIOD(P),
        .POLL_BITS  (16),
        .REQ_CYCLES (R),
        .TIMEOUT    (T),
        .TO_BITS    (5)
    ) dut (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .STB_O     (STB_O),
        .STB_I     (STB_I),
        .DAT_I     (DAT_I),
        .o_state   (o_state),
        .o_pressed (o_pressed),
        .o_released(o_released),
        .o_timeout (o_timeout),
        .o_err_cnt (o_err_cnt)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    function automatic int sat_err(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // Counts edges until STB_O is seen high; optional junk strobes while idle.
    task automatic wait_rise(input bit noise, input int expect_n, input string tag);
        int n = 0;
        bit seen = 1'b0;
        while (n < 200 && !seen) begin
            if (noise) begin
                STB_I = 1'($urandom);
                DAT_I = 8'hFF;
            end
            step();
            n++;
            if (STB_O === 1'b1) seen = 1'b1;
            else begin
                chk({tag, "_idle_pr"}, 32'(o_pressed), 32'(8'h00));
                chk({tag, "_idle_rl"}, 32'(o_released), 32'(8'h00));
                chk({tag, "_idle_st"}, 32'(o_state), 32'(exp_state));
            end
        end
        STB_I = 1'b0;
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        chk({tag, "_gap"}, 32'(n), 32'(expect_n));
    endtask

    // Entered one step after STB_O rose; leaves one step after the next rise.
    task automatic txn(input bit respond, input logic [7:0] data, input int d, input bit noise);
        logic [7:0] ep, er;
        chk("stb_hi1", 32'(STB_O), 32'd1);
        if (noise) begin
            STB_I = 1'b1;
            DAT_I = 8'hFF;
        end
        step();
        STB_I = 1'b0;
        chk("stb_hi2", 32'(STB_O), 32'd1);
        step();
        chk("stb_lo", 32'(STB_O), 32'd0);
        if (respond) begin
            repeat (d) step();
            STB_I = 1'b1;
            DAT_I = data;
            step();
            STB_I = 1'b0;
            DAT_I = 8'($urandom);
            chk("state_hold", 32'(o_state), 32'(exp_state));
            step();
            ep = primed ? (data & ~exp_state) : 8'h00;
            er = primed ? (~data & exp_state) : 8'h00;
            chk("pressed", 32'(o_pressed), 32'(ep));
            chk("released", 32'(o_released), 32'(er));
            chk("state", 32'(o_state), 32'(data));
            chk("no_tmo", 32'(o_timeout), 32'd0);
            chk("err_keep", 32'(o_err_cnt), 32'(exp_err));
            p0_cnt += int'(o_pressed[0]);
            r0_cnt += int'(o_released[0]);
            exp_state = data;
            primed    = 1'b1;
            step();
            chk("pr_clear", 32'(o_pressed), 32'(8'h00));
            chk("rl_clear", 32'(o_released), 32'(8'h00));
        end else begin
            repeat (T - 1) step();
            chk("tmo_early", 32'(o_timeout), 32'd0);
            step();
            exp_err = sat_err(exp_err);
            tmo_cnt++;
            chk("tmo_pulse", 32'(o_timeout), 32'd1);
            chk("err_cnt", 32'(o_err_cnt), 32'(exp_err));
            chk("tmo_state", 32'(o_state), 32'(exp_state));
            chk("tmo_pr", 32'(o_pressed), 32'(8'h00));
            step();
            chk("tmo_clear", 32'(o_timeout), 32'd0);
        end
        wait_rise(noise, P - 1, "poll");
    endtask

    initial begin
        #2 RST_I = 1'b0;
        #1;
        chk("rst_stb", 32'(STB_O), 32'd0);
        chk("rst_state", 32'(o_state), 32'(8'h00));
        chk("rst_pr", 32'(o_pressed), 32'(8'h00));
        chk("rst_rl", 32'(o_released), 32'(8'h00));
        chk("rst_tmo", 32'(o_timeout), 32'd0);
        chk("rst_err", 32'(o_err_cnt), 32'(8'h00));
        repeat (3) step();
        RST_I = 1'b1;
        wait_rise(1'b0, P, "first_req");

        txn(1'b1, 8'h01, 0, 1'b0);

        // Reset in the middle of a request.
        step();
        chk("midreq_stb", 32'(STB_O), 32'd1);
        RST_I = 1'b0;
        #1;
        chk("arst_stb", 32'(STB_O), 32'd0);
        chk("arst_state", 32'(o_state), 32'(8'h00));
        chk("arst_err", 32'(o_err_cnt), 32'(8'h00));
        exp_state = 8'h00;
        exp_err   = 0;
        primed    = 1'b0;
        repeat (2) step();
        RST_I = 1'b1;
        wait_rise(1'b0, P, "rst_req");

        txn(1'b1, 8'h01, 1, 1'b0);
        chk("primed_sup", 32'(o_state), 32'(8'h01));
        txn(1'b1, 8'h00, 0, 1'b0);
        txn(1'b1, 8'h05, 3, 1'b0);
        txn(1'b1, 8'h04, 2, 1'b0);
        chk("seq_state", 32'(o_state), 32'(8'h04));

        txn(1'b0, 8'h00, 0, 1'b0);
        chk("one_err", 32'(o_err_cnt), 32'd1);

        txn(1'b1, 8'h0A, 2, 1'b1);
        txn(1'b1, 8'h3C, T - 1, 1'b0);
        txn(1'b1, 8'hC3, 0, 1'b1);

        for (int i = 0; i < 30; i++) begin
            txn(($urandom_range(0, 9) != 0), 8'($urandom), $urandom_range(0, T - 1),
                1'($urandom));
        end

        // Single button pressed then released across 20 polls.
        txn(1'b1, 8'h00, 0, 1'b0);
        p0_cnt  = 0;
        r0_cnt  = 0;
        tmo_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            txn(1'b1, (i >= 5 && i < 12) ? 8'h01 : 8'h00, $urandom_range(0, T - 1), 1'b0);
        end
        chk("btn_press_cnt", 32'(p0_cnt), 32'd1);
        chk("btn_rel_cnt", 32'(r0_cnt), 32'd1);
        chk("btn_tmo_cnt", 32'(tmo_cnt), 32'd0);

        for (int i = 0; i < 300; i++) begin
            txn(1'b0, 8'h00, 0, 1'b0);
        end
        chk("err_sat", 32'(o_err_cnt), 32'd255);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
